axi4s_fifo_param: RTL

//  Parametrised AXI4-Stream FIFO; next generation of the simple AXI4-Stream FIFO peripheral.

---
 rtl/axi4s_fifo_pkg.sv | 30 +++
 rtl/axi4s_fifo_mem.sv | 24 ++
 rtl/axi4s_fifo_param.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axi4s_fifo_pkg.sv
// Shared types and helpers for the parametrised AXI4-Stream FIFO.
package axi4s_fifo_pkg;

  // Packet-aware overflow handling state.
  typedef enum logic {
    DROP_IDLE   = 1'b0,
    DROP_ACTIVE = 1'b1
  } drop_state_t;

  // Pointers carry one extra wrap bit above the address bits. Callers
  // zero-extend them to 32 bits so one helper serves every FIFO depth.
  function automatic logic [31:0] ptr_mask(input int addr_w);
    return (32'd1 << (addr_w + 1)) - 32'd1;
  endfunction

  // Empty: both pointers identical, including the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] wr_ptr,
                                     input logic [31:0] rd_ptr,
                                     input int          addr_w);
    return ((wr_ptr ^ rd_ptr) & ptr_mask(addr_w)) == 32'd0;
  endfunction

  // Full: wrap bits differ, address bits identical.
  function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                    input logic [31:0] rd_ptr,
                                    input int          addr_w);
    return ((wr_ptr ^ rd_ptr) & ptr_mask(addr_w)) == (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/axi4s_fifo_mem.sv
// Storage array for the stream FIFO: synchronous write, asynchronous read,
// so the head entry is visible combinationally (first-word-fall-through).
module axi4s_fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4s_fifo_param.sv
// Parametrised AXI4-Stream FIFO with TLAST, occupancy/almost-full status,
// flush and optional packet-aware drop-on-full with a saturating drop counter.
module axi4s_fifo_param
  import axi4s_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  input  logic                   FLUSH,
  output logic [$clog2(DEPTH):0] OCCUPANCY,
  output logic                   ALMOST_FULL,
  output logic [CNT_WIDTH-1:0]   OVERFLOW_CNT
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     occ_q, occ_d;
  logic                 afull_q, afull_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  drop_state_t          state_q, state_d, fsm_next;
  logic                 rdy_q;

  logic                 full, empty;
  logic                 beat_in, drop_beat, push, pop;
  logic [DATA_WIDTH:0]  rd_word;

  assign full  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);
  assign empty = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_W);

  // Ready depends only on registered state, never on M_AXIS_TREADY.
  assign S_AXIS_TREADY = rdy_q & ((DROP_ON_FULL != 0) | ~full);
  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = rd_word[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = rd_word[DATA_WIDTH];
  assign OCCUPANCY     = occ_q;
  assign ALMOST_FULL   = afull_q;
  assign OVERFLOW_CNT  = cnt_q;

  assign beat_in = S_AXIS_TVALID & S_AXIS_TREADY;
  assign push    = beat_in & ~full & ~drop_beat & ~FLUSH;
  assign pop     = M_AXIS_TVALID & M_AXIS_TREADY & ~FLUSH;

  axi4s_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (ACLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_word)
  );

  // Drop FSM: once a packet overflows, the rest of it is discarded up to TLAST
  // so the consumer never sees beats from the middle of a packet spliced in.
  always_comb begin
    fsm_next  = state_q;
    drop_beat = 1'b0;
    if ((DROP_ON_FULL != 0) && beat_in) begin
      case (state_q)
        DROP_IDLE: begin
          if (full) begin
            drop_beat = 1'b1;
            if (!S_AXIS_TLAST) fsm_next = DROP_ACTIVE;
          end
        end
        DROP_ACTIVE: begin
          drop_beat = 1'b1;
          if (S_AXIS_TLAST) fsm_next = DROP_IDLE;
        end
        default: fsm_next = DROP_IDLE;
      endcase
    end
  end

  // Next-state for pointers, occupancy, status and the drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    state_d  = fsm_next;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      state_d  = DROP_IDLE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + PTR_W'(1);
        2'b01:   occ_d = occ_q - PTR_W'(1);
        default: occ_d = occ_q;
      endcase
      if (drop_beat && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    afull_d = (occ_d >= PTR_W'(AFULL_THRESH));
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      afull_q  <= 1'b0;
      cnt_q    <= '0;
      state_q  <= DROP_IDLE;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      afull_q  <= afull_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule
